// File: rtl/xil_mem_dp_arb_pkg.sv
// Shared memory-port constants and lane parity helpers for xil_mem_dp_arb.
// The parity helpers are used only when XIL_MEM_ARB_PARITY_EN is defined.
package xil_mem_dp_arb_pkg;
   localparam int MEM_ADR_W  = 9;
   localparam int MEM_DATA_W = 36;
   localparam int MEM_LANES  = 4;
   localparam int MEM_LANE_W = 9;

   typedef logic [MEM_ADR_W-1:0]  mem_adr_t;
   typedef logic [MEM_DATA_W-1:0] mem_data_t;
   typedef logic [MEM_LANES-1:0]  mem_wen_t;

   // Replace the top bit of every 9-bit lane with even parity of its low 8 bits.
   function automatic mem_data_t set_lane_parity(input mem_data_t d);
      mem_data_t r;
      r = d;
      for (int i = 0; i < MEM_LANES; i++) begin
         r[i*MEM_LANE_W + MEM_LANE_W-1] = ^d[i*MEM_LANE_W +: MEM_LANE_W-1];
      end
      return r;
   endfunction

   // High when any lane's stored parity bit disagrees with its data bits.
   function automatic logic lane_parity_err(input mem_data_t d);
      logic e;
      e = 1'b0;
      for (int i = 0; i < MEM_LANES; i++) begin
         e = e | (d[i*MEM_LANE_W + MEM_LANE_W-1] ^ (^d[i*MEM_LANE_W +: MEM_LANE_W-1]));
      end
      return e;
   endfunction
endpackage

// File: rtl/xil_mem_dp_arb_if.sv
// Requester-side bus of xil_mem_dp_arb.
// Handshake: i_req[k] is valid, o_req_gnt[k] is ready; a command transfers in the
// cycle both are high, and the requester holds i_req and its command stable until then.
// Read data returns on o_rd_valid/o_rd_data two cycles after the grant, with no back-pressure.
interface xil_mem_dp_arb_if #(parameter int NUM_REQ = 4);
   import xil_mem_dp_arb_pkg::*;

   logic [NUM_REQ-1:0]            i_req;
   logic [NUM_REQ-1:0]            i_req_lock;
   logic [MEM_LANES*NUM_REQ-1:0]  i_req_wen;
   logic [MEM_ADR_W*NUM_REQ-1:0]  i_req_adr;
   logic [MEM_DATA_W*NUM_REQ-1:0] i_req_wdata;
   logic [NUM_REQ-1:0]            o_req_gnt;
   logic [NUM_REQ-1:0]            o_rd_valid;
   logic [MEM_DATA_W-1:0]         o_rd_data;
   logic                          o_rd_perr;

   modport slave (
      input  i_req, i_req_lock, i_req_wen, i_req_adr, i_req_wdata,
      output o_req_gnt, o_rd_valid, o_rd_data, o_rd_perr
   );

   modport master (
      output i_req, i_req_lock, i_req_wen, i_req_adr, i_req_wdata,
      input  o_req_gnt, o_rd_valid, o_rd_data, o_rd_perr
   );
endinterface

// File: rtl/xil_mem_arb_rr.sv
// Combinational round-robin picker: first asserted request at or after the pointer,
// wrapping modulo NUM_REQ. Returns one-hot grant, encoded index and an any-grant flag.
module xil_mem_arb_rr #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = 2
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [IDX_W-1:0]   i_ptr,
   output logic [NUM_REQ-1:0] o_gnt,
   output logic [IDX_W-1:0]   o_idx,
   output logic               o_any
);
   int w_j;

   // Scan from the pointer position and take the first requester found.
   always_comb begin
      o_gnt = '0;
      o_idx = '0;
      o_any = 1'b0;
      w_j   = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         w_j = int'(i_ptr) + i;
         if (w_j >= NUM_REQ) begin
            w_j = w_j - NUM_REQ;
         end
         if (!o_any && i_req[w_j]) begin
            o_gnt[w_j] = 1'b1;
            o_idx      = IDX_W'(w_j);
            o_any      = 1'b1;
         end
      end
   end
endmodule

// File: rtl/xil_mem_dp_arb.sv
// Round-robin arbiter sharing one port of a 512x36 dual-port block memory.
// Registers the winning command onto the memory port and returns read data two
// cycles after grant. Optional lane parity: define XIL_MEM_ARB_PARITY_EN.
module xil_mem_dp_arb
   import xil_mem_dp_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int MAX_LOCK = 8
) (
   input  logic              clk,
   input  logic              rst,
   xil_mem_dp_arb_if.slave   req_if,
   output logic              o_mem_en,
   output mem_wen_t          o_mem_wen,
   output mem_adr_t          o_mem_adr,
   output mem_data_t         o_mem_wdata,
   input  mem_data_t         i_mem_rdata
);
   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_LOCK) + 1;
   localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(MAX_LOCK - 1);
   localparam logic [IDX_W-1:0] IDX_MAX   = IDX_W'(NUM_REQ - 1);

   logic [IDX_W-1:0]   r_ptr;
   logic [CNT_W-1:0]   r_lock_cnt;
   logic [NUM_REQ-1:0] r_tag1;
   logic [NUM_REQ-1:0] r_tag2;
   logic               r_mem_en;
   mem_wen_t           r_mem_wen;
   mem_adr_t           r_mem_adr;
   mem_data_t          r_mem_wdata;

   logic [NUM_REQ-1:0] w_pick_gnt;
   logic [IDX_W-1:0]   w_idx;
   logic               w_pick_any;
   logic               w_any;
   logic               w_lock;
   mem_wen_t           w_wen;
   mem_adr_t           w_adr;
   mem_data_t          w_raw;
   mem_data_t          w_wdata;
   logic               w_perr;

   xil_mem_arb_rr #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr (
      .i_req (req_if.i_req),
      .i_ptr (r_ptr),
      .o_gnt (w_pick_gnt),
      .o_idx (w_idx),
      .o_any (w_pick_any)
   );

   // No grant is ever issued while reset is held.
   assign req_if.o_req_gnt = rst ? '0 : w_pick_gnt;
   assign w_any  = w_pick_any & ~rst;
   assign w_lock = req_if.i_req_lock[w_idx];
   assign w_wen  = req_if.i_req_wen[w_idx*MEM_LANES +: MEM_LANES];
   assign w_adr  = req_if.i_req_adr[w_idx*MEM_ADR_W +: MEM_ADR_W];
   assign w_raw  = req_if.i_req_wdata[w_idx*MEM_DATA_W +: MEM_DATA_W];

`ifdef XIL_MEM_ARB_PARITY_EN
   assign w_wdata = set_lane_parity(w_raw);
   assign w_perr  = lane_parity_err(i_mem_rdata);
`else
   assign w_wdata = w_raw;
   assign w_perr  = 1'b0;
`endif

   // Register the winning command onto the memory port; idle cycles force enables low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mem_en    <= 1'b0;
         r_mem_wen   <= '0;
         r_mem_adr   <= '0;
         r_mem_wdata <= '0;
      end else begin
         r_mem_en  <= w_any;
         r_mem_wen <= w_any ? w_wen : '0;
         if (w_any) begin
            r_mem_adr   <= w_adr;
            r_mem_wdata <= w_wdata;
         end
      end
   end

   // Two-stage read tag pipeline lined up with the memory's one-cycle read latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_tag1 <= '0;
         r_tag2 <= '0;
      end else begin
         r_tag1 <= (w_any && (w_wen == '0)) ? w_pick_gnt : '0;
         r_tag2 <= r_tag1;
      end
   end

   // Priority pointer and lock counter: a locking winner keeps priority up to MAX_LOCK grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_ptr      <= '0;
         r_lock_cnt <= '0;
      end else if (w_any) begin
         if (w_lock && (r_lock_cnt < LOCK_LAST)) begin
            r_ptr      <= w_idx;
            r_lock_cnt <= r_lock_cnt + 1'b1;
         end else begin
            r_ptr      <= (w_idx == IDX_MAX) ? '0 : w_idx + 1'b1;
            r_lock_cnt <= '0;
         end
      end else begin
         r_lock_cnt <= '0;
      end
   end

   assign o_mem_en          = r_mem_en;
   assign o_mem_wen         = r_mem_wen;
   assign o_mem_adr         = r_mem_adr;
   assign o_mem_wdata       = r_mem_wdata;
   assign req_if.o_rd_valid = r_tag2;
   assign req_if.o_rd_data  = i_mem_rdata;
   assign req_if.o_rd_perr  = (|r_tag2) & w_perr;
endmodule
